// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S output path.
package audio_pkg;

  localparam int ADDR_W   = 25;
  localparam int SAMPLE_W = 16;

  // Word address of the WAV payload in SDRAM.
  localparam logic [ADDR_W-1:0] PCM_DEFAULT_START = 25'h4f;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    FULL_WAIT = 2'd2,
    DISCARD   = 2'd3
  } fetch_state_t;

  // Exchange the two bytes of a PCM word.
  function automatic logic [SAMPLE_W-1:0] swap_bytes(input logic [SAMPLE_W-1:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO. The head word, occupancy and not-empty flag
// are all registered; an empty FIFO presents zero at the head.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   not_empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             not_empty_q, not_empty_d;
  logic             push_eff_s, pop_eff_s;

  // Next pointers, occupancy and head word; flush overrides any push/pop.
  always_comb begin
    pop_eff_s  = pop & (count_q != {CNT_W{1'b0}});
    push_eff_s = push & (count_q != CNT_FULL) & ~flush;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    head_d     = {WIDTH{1'b0}};
    if (flush) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff_s);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_eff_s);
      count_d  = count_q + CNT_W'(push_eff_s) - CNT_W'(pop_eff_s);
    end
    // The word being written becomes the head only when nothing older survives.
    if (count_d == {CNT_W{1'b0}}) begin
      head_d = {WIDTH{1'b0}};
    end else if (push_eff_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_data;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    not_empty_d = (count_d != {CNT_W{1'b0}});
  end

  // Storage write port; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_eff_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer, occupancy and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= {PTR_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      head_q      <= {WIDTH{1'b0}};
      not_empty_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      not_empty_q <= not_empty_d;
    end
  end

  assign head_data = head_q;
  assign not_empty = not_empty_q;
  assign count     = count_q;

endmodule

// File: rtl/pcm_prefetch_fifo.sv
// PCM prefetcher: reads a window of 16-bit words from SDRAM over the Avalon
// bridge, one read in flight at a time, into a show-ahead FIFO that the I2S
// serializer drains. Supports one-shot and looped playback.
module pcm_prefetch_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int SWAP_BYTES = 0
) (
  input  logic                   clk50,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic [ADDR_W-1:0]      addr_start,
  input  logic [ADDR_W-1:0]      addr_end,
  output logic [ADDR_W-1:0]      avm_address,
  output logic                   avm_read,
  input  logic [SAMPLE_W-1:0]    avm_readdata,
  input  logic                   avalon_bridge_acknowledge,
  input  logic                   sample_pop,
  output logic [SAMPLE_W-1:0]    sample_data,
  output logic                   sample_valid,
  output logic                   underrun,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] win_start_q, win_start_d;
  logic [ADDR_W-1:0] win_end_q, win_end_d;
  logic              loop_q, loop_d;
  logic              read_q, read_d;
  logic              pend_start_q, pend_start_d;
  logic              underrun_q, underrun_d;
  logic              busy_q, busy_d;

  logic              ack_s;
  logic              push_s;
  logic              flush_s;
  logic              pop_eff_s;
  logic              full_after_s;
  logic              in_flight_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [SAMPLE_W-1:0] push_data_s;

  // Derived per-cycle conditions shared by the FSM.
  always_comb begin
    ack_s        = avalon_bridge_acknowledge;
    next_addr_s  = addr_q + 25'd1;
    pop_eff_s    = sample_pop & sample_valid;
    // A push that lands the FIFO at DEPTH (no same-cycle pop) must stop fetching.
    full_after_s = (fill_level == CNT_ALMOST) & ~pop_eff_s;
    // A read is still owed by the bridge: aborts must wait for its ack.
    in_flight_s  = ((state_q == FETCH) || (state_q == DISCARD)) & ~ack_s;
    if (SWAP_BYTES != 0) begin
      push_data_s = swap_bytes(avm_readdata);
    end else begin
      push_data_s = avm_readdata;
    end
  end

  // Next-state logic: control pulses first (start beats stop), then per-state work.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    win_start_d  = win_start_q;
    win_end_d    = win_end_q;
    loop_d       = loop_q;
    read_d       = read_q;
    pend_start_d = pend_start_q;
    underrun_d   = underrun_q | (sample_pop & ~sample_valid);
    push_s       = 1'b0;
    flush_s      = start | stop;

    if (start) begin
      win_start_d = addr_start;
      win_end_d   = addr_end;
      loop_d      = loop_en;
      underrun_d  = 1'b0;
      if (in_flight_s) begin
        state_d      = DISCARD;
        pend_start_d = 1'b1;
        read_d       = 1'b1;
      end else if (addr_end > addr_start) begin
        state_d = FETCH;
        addr_d  = addr_start;
        read_d  = 1'b1;
      end else begin
        state_d = IDLE;
        read_d  = 1'b0;
      end
    end else if (stop) begin
      if (in_flight_s) begin
        state_d      = DISCARD;
        pend_start_d = 1'b0;
        read_d       = 1'b1;
      end else begin
        state_d = IDLE;
        read_d  = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          read_d = 1'b0;
        end
        FETCH: begin
          if (ack_s) begin
            push_s = 1'b1;
            if (next_addr_s == win_end_q) begin
              addr_d = win_start_q;
            end else begin
              addr_d = next_addr_s;
            end
            if ((next_addr_s == win_end_q) && !loop_q) begin
              addr_d  = next_addr_s;
              state_d = IDLE;
              read_d  = 1'b0;
            end else if (full_after_s) begin
              state_d = FULL_WAIT;
              read_d  = 1'b0;
            end else begin
              state_d = FETCH;
              read_d  = 1'b1;
            end
          end else begin
            read_d = 1'b1;
          end
        end
        FULL_WAIT: begin
          if (fill_level != CNT_FULL) begin
            state_d = FETCH;
            read_d  = 1'b1;
          end else begin
            read_d = 1'b0;
          end
        end
        DISCARD: begin
          if (ack_s) begin
            if (pend_start_q && (win_end_q > win_start_q)) begin
              state_d = FETCH;
              addr_d  = win_start_q;
              read_d  = 1'b1;
            end else begin
              state_d = IDLE;
              read_d  = 1'b0;
            end
          end else begin
            read_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          read_d  = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // FSM, address counter, window latch and registered flags.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      win_start_q  <= {ADDR_W{1'b0}};
      win_end_q    <= {ADDR_W{1'b0}};
      loop_q       <= 1'b0;
      read_q       <= 1'b0;
      pend_start_q <= 1'b0;
      underrun_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      win_start_q  <= win_start_d;
      win_end_q    <= win_end_d;
      loop_q       <= loop_d;
      read_q       <= read_d;
      pend_start_q <= pend_start_d;
      underrun_q   <= underrun_d;
      busy_q       <= busy_d;
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk50),
    .reset     (reset),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (sample_pop),
    .head_data (sample_data),
    .not_empty (sample_valid),
    .count     (fill_level)
  );

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign underrun    = underrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pcm_prefetch_fifo.sv
module tb_pcm_prefetch_fifo;

  logic        clk50 = 1'b0;
  logic        reset, start, stop, loop_en, ack, sample_pop;
  logic [24:0] addr_start, addr_end;
  logic [15:0] rdata;

  logic [24:0] avm_address, s_avm_address;
  logic        avm_read, s_avm_read;
  logic [15:0] sample_data, s_sample_data;
  logic        sample_valid, s_sample_valid, underrun, s_underrun, busy, s_busy;
  logic [4:0]  fill_level, s_fill_level;

  int          n_vec = 0;
  int          n_bad = 0;
  int          lat = 3;
  int          cnt = 0;
  int          ack_count = 0;
  bit          ovr_en = 1'b0;
  logic [24:0] acked_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  always #10 clk50 = ~clk50;

  pcm_prefetch_fifo #(.DEPTH(16), .SWAP_BYTES(0)) dut (
    .clk50(clk50), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .addr_start(addr_start), .addr_end(addr_end), .avm_address(avm_address),
    .avm_read(avm_read), .avm_readdata(rdata), .avalon_bridge_acknowledge(ack),
    .sample_pop(sample_pop), .sample_data(sample_data), .sample_valid(sample_valid),
    .underrun(underrun), .busy(busy), .fill_level(fill_level));

  // Twin with byte swapping, fed identically; its bus timing mirrors the first.
  pcm_prefetch_fifo #(.DEPTH(16), .SWAP_BYTES(1)) dut_sw (
    .clk50(clk50), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .addr_start(addr_start), .addr_end(addr_end), .avm_address(s_avm_address),
    .avm_read(s_avm_read), .avm_readdata(rdata), .avalon_bridge_acknowledge(ack),
    .sample_pop(sample_pop), .sample_data(s_sample_data), .sample_valid(s_sample_valid),
    .underrun(s_underrun), .busy(s_busy), .fill_level(s_fill_level));

  function automatic logic [15:0] mem_word(input logic [24:0] a);
    if (a == 25'h200) return 16'h1234;
    else return {4'hC, a[11:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic pulse_ctl(input logic [24:0] s, input logic [24:0] e, input logic lp,
                           input logic do_start, input logic do_stop);
    @(posedge clk50); #1;
    addr_start = s; addr_end = e; loop_en = lp; start = do_start; stop = do_stop;
    @(posedge clk50); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk50); #1;
      sample_pop = 1'b1;
    end
    @(posedge clk50); #1;
    sample_pop = 1'b0;
  endtask

  // Memory responder: acks a held read after 'lat' cycles.
  initial begin
    ack = 1'b0; rdata = 16'h0000;
    forever begin
      @(posedge clk50); #1;
      ack = 1'b0; rdata = 16'h0000;
      if (avm_read === 1'b1 && reset === 1'b0) begin
        cnt++;
        if (cnt >= lat) begin
          ack = 1'b1;
          rdata = ovr_en ? 16'hBEEF : mem_word(avm_address);
          cnt = 0;
          ack_count++;
          acked_q.push_back(avm_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every accepted pop is checked against the expected queue.
  always @(negedge clk50) begin
    if (sample_pop && sample_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb_extra: popped %h with nothing expected", sample_data);
      end else begin
        exp_w = exp_q.pop_front();
        n_vec++;
        if (sample_data !== exp_w) begin
          n_bad++;
          $display("FAIL sb_data: got %h expected %h", sample_data, exp_w);
        end
        n_vec++;
        if (s_sample_data !== {exp_w[7:0], exp_w[15:8]}) begin
          n_bad++;
          $display("FAIL sb_swap: got %h expected %h", s_sample_data, {exp_w[7:0], exp_w[15:8]});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; sample_pop = 1'b0;
    addr_start = 25'h0; addr_end = 25'h0;
    repeat (3) @(posedge clk50);
    @(negedge clk50);
    chk("rst_read", avm_read, 1'b0);
    chk("rst_addr", avm_address, 25'h0);
    chk("rst_data", sample_data, 16'h0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fill", fill_level, 5'd0);
    @(posedge clk50); #1; reset = 1'b0;

    // Basic one-shot fetch 0x4f..0x52, latency 3.
    lat = 3; ack_count = 0; acked_q.delete();
    pulse_ctl(25'h4f, 25'h53, 1'b0, 1'b1, 1'b0);
    @(negedge clk50);
    chk("t1_busy", busy, 1'b1);
    chk("t1_read", avm_read, 1'b1);
    chk("t1_addr", avm_address, 25'h4f);
    for (int a = 'h4f; a < 'h53; a++) exp_q.push_back(mem_word(25'(a)));
    for (int t = 0; t < 100; t++) begin
      @(negedge clk50);
      if (!busy) break;
    end
    chk("t1_done", busy, 1'b0);
    chk("t1_acks", ack_count, 4);
    chk("t1_a0", acked_q[0], 25'h4f);
    chk("t1_a3", acked_q[3], 25'h52);
    chk("t1_fill", fill_level, 5'd4);
    chk("t1_head", sample_data, 16'hC04F);
    pop_n(4);
    @(negedge clk50);
    chk("t1_empty", sample_valid, 1'b0);
    chk("t1_zero", sample_data, 16'h0);

    // Fill to depth, then one pop lets exactly one more read through.
    lat = 1; ack_count = 0; acked_q.delete();
    pulse_ctl(25'h1000, 25'h2000, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(mem_word(25'h1000));
    repeat (60) @(negedge clk50);
    chk("t2_acks16", ack_count, 16);
    chk("t2_noread", avm_read, 1'b0);
    chk("t2_fill16", fill_level, 5'd16);
    chk("t2_busy", busy, 1'b1);
    pop_n(1);
    repeat (10) @(negedge clk50);
    chk("t2_acks17", ack_count, 17);
    chk("t2_refill", fill_level, 5'd16);
    chk("t2_noread2", avm_read, 1'b0);
    chk("t2_a16", acked_q[16], 25'h1010);
    pulse_ctl(25'h0, 25'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk50);
    chk("t2_stop_fill", fill_level, 5'd0);
    chk("t2_stop_busy", busy, 1'b0);

    // Looped window 0x100..0x102.
    lat = 2; ack_count = 0; acked_q.delete();
    pulse_ctl(25'h100, 25'h103, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(mem_word(25'h100)); exp_q.push_back(mem_word(25'h101));
    exp_q.push_back(mem_word(25'h102)); exp_q.push_back(mem_word(25'h100));
    repeat (80) @(negedge clk50);
    chk("t3_a2", acked_q[2], 25'h102);
    chk("t3_a3", acked_q[3], 25'h100);
    chk("t3_a4", acked_q[4], 25'h101);
    chk("t3_a6", acked_q[6], 25'h100);
    chk("t3_fill", fill_level, 5'd16);
    pop_n(4);
    pulse_ctl(25'h0, 25'h0, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk50);
    chk("t3_idle", busy, 1'b0);
    chk("t3_fill0", fill_level, 5'd0);

    // Abort while a read is outstanding; 0xBEEF must be dropped.
    lat = 6; ovr_en = 1'b1;
    pulse_ctl(25'h300, 25'h310, 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    @(posedge clk50); #1; stop = 1'b0;
    @(negedge clk50);
    chk("t4_discard_busy", busy, 1'b1);
    chk("t4_discard_read", avm_read, 1'b1);
    for (int t = 0; t < 20; t++) begin
      if (ack) break;
      @(negedge clk50);
    end
    chk("t4_ack", ack, 1'b1);
    @(negedge clk50);
    ovr_en = 1'b0;
    chk("t4_idle", busy, 1'b0);
    chk("t4_read", avm_read, 1'b0);
    chk("t4_fill", fill_level, 5'd0);
    chk("t4_valid", sample_valid, 1'b0);
    chk("t4_data", sample_data, 16'h0);

    // Underrun, then push and pop together at fill_level 1.
    @(posedge clk50); #1; sample_pop = 1'b1;
    @(posedge clk50); #1; sample_pop = 1'b0;
    @(negedge clk50);
    chk("t5_underrun", underrun, 1'b1);
    chk("t5_fill", fill_level, 5'd0);
    lat = 3;
    pulse_ctl(25'h400, 25'h402, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(mem_word(25'h400)); exp_q.push_back(mem_word(25'h401));
    for (int t = 0; t < 20; t++) begin
      @(negedge clk50);
      if (t == 0) chk("t5_underrun_clr", underrun, 1'b0);
      if (ack) break;
    end
    chk("t5_ack1", ack, 1'b1);
    repeat (3) @(posedge clk50);
    #2 sample_pop = 1'b1;
    @(negedge clk50);
    chk("t5_ack2", ack, 1'b1);
    chk("t5_fill1", fill_level, 5'd1);
    @(posedge clk50); #1; sample_pop = 1'b0;
    @(negedge clk50);
    chk("t5_fill_keep", fill_level, 5'd1);
    chk("t5_head", sample_data, 16'hC401);
    chk("t5_busy", busy, 1'b0);
    pop_n(1);

    // Byte swap of 0x1234.
    lat = 2;
    pulse_ctl(25'h200, 25'h201, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(16'h1234);
    repeat (6) @(negedge clk50);
    chk("t6_fill", fill_level, 5'd1);
    chk("t6_plain", sample_data, 16'h1234);
    chk("t6_swap", s_sample_data, 16'h3412);
    pop_n(1);

    // Zero-length window stays idle.
    pulse_ctl(25'h700, 25'h700, 1'b0, 1'b1, 1'b0);
    @(negedge clk50);
    chk("t7_zero_busy", busy, 1'b0);
    chk("t7_zero_read", avm_read, 1'b0);

    // start and stop together: start wins.
    lat = 1;
    pulse_ctl(25'h600, 25'h602, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(mem_word(25'h600)); exp_q.push_back(mem_word(25'h601));
    @(negedge clk50);
    chk("t8_read", avm_read, 1'b1);
    chk("t8_addr", avm_address, 25'h600);
    repeat (5) @(negedge clk50);
    chk("t8_fill", fill_level, 5'd2);
    pop_n(2);

    // Reset in the middle of a read.
    lat = 4;
    pulse_ctl(25'h500, 25'h510, 1'b0, 1'b1, 1'b0);
    @(posedge clk50); #1; reset = 1'b1;
    @(posedge clk50);
    @(negedge clk50);
    chk("t9_read", avm_read, 1'b0);
    chk("t9_addr", avm_address, 25'h0);
    chk("t9_busy", busy, 1'b0);
    @(posedge clk50); #1; reset = 1'b0;
    repeat (2) @(negedge clk50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
